digest_tx: RTL



---
 rtl/digest_tx.sv | 108 ++++++++++
 1 files changed

// File: rtl/digest_tx.sv
// digest_tx: captures the finished BLAKE2 state and streams the first nn digest
// bytes out under valid/ready. Optional length-prefix byte: DIGEST_TX_LEN_PREFIX_EN.
module digest_tx #(
  parameter int NN_MAX = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  digest_v_i,
  input  logic [8*NN_MAX-1:0]   digest_i,
  input  logic [7:0]            nn_i,
  input  logic                  ready_i,
  output logic                  hash_v_o,
  output logic [7:0]            hash_o,
  output logic                  hash_last_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int CNT_W = $clog2(NN_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef DIGEST_TX_LEN_PREFIX_EN
    LEN  = 2'd2,
`endif
    SEND = 2'd1
  } state_t;

  state_t                state, state_nxt;
  logic [8*NN_MAX-1:0]   shreg;
  logic [CNT_W-1:0]      cnt;
  logic                  err;

  // Out-of-range lengths (0 or beyond the capture register) mean "full digest".
  function automatic logic [CNT_W-1:0] sat_len(input logic [7:0] nn);
    if (nn == 8'd0 || 32'(nn) > NN_MAX) return CNT_W'(NN_MAX);
    return CNT_W'(nn);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    hash_v_o    = 1'b0;
    hash_o      = 8'd0;
    hash_last_o = 1'b0;
    busy_o      = 1'b0;
    case (state)
      IDLE: begin
        if (digest_v_i) begin
`ifdef DIGEST_TX_LEN_PREFIX_EN
          state_nxt = LEN;
`else
          state_nxt = SEND;
`endif
        end
      end
`ifdef DIGEST_TX_LEN_PREFIX_EN
      LEN: begin
        hash_v_o = 1'b1;
        hash_o   = 8'(cnt);
        busy_o   = 1'b1;
        if (ready_i) state_nxt = SEND;
      end
`endif
      SEND: begin
        hash_v_o    = 1'b1;
        hash_o      = shreg[7:0];
        hash_last_o = (cnt == CNT_W'(1));
        busy_o      = 1'b1;
        if (ready_i && cnt == CNT_W'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture / shift datapath; a capture request while busy only raises the sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      if (state != IDLE && digest_v_i) err <= 1'b1;
      case (state)
        IDLE: begin
          if (digest_v_i) begin
            shreg <= digest_i;
            cnt   <= sat_len(nn_i);
          end
        end
        SEND: begin
          if (ready_i) begin
            shreg <= shreg >> 8;
            cnt   <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign err_o = err;

endmodule
